alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Width-parametrised, handshaked successor to the 8-bit datapath ALU.
- Single-cycle ops: arithmetic, logic and one-bit shift/rotate, with corrected flags.
- Multi-cycle ops:
  - multi-bit shifts/rotates, one bit per cycle;
  - unsigned shift-add multiply producing a double-width result.
- Sits between the register file and the CPU control FSM. Control raises start, then waits for done.

Parameters:
- WIDTH, 8, operand/result width; legal range 4..32.
- SHAMT_W, $clog2(WIDTH), localparam, width of shift amount; not overridable.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- start  in  1  launch operation; accepted only when busy=0
- single  in  1  selects single-operand op group (same meaning as legacy ALU)
- operator  in  4  op code, constants from cpu_data
- value1  in  WIDTH  operand A (destination register value)
- value2  in  WIDTH  operand B
- shamt  in  SHAMT_W  shift/rotate count for multi-bit shift ops
- old_carry  in  1  carry flag from status register
- busy  out  1  high while a multi-cycle op runs
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- bus_out  out  WIDTH  result (low half for MUL)
- bus_out_hi  out  WIDTH  high half of MUL; 0 for every other op
- alu_flags  out  4  {carry, overflow, zero, negative}

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; busy, done, bus_out, bus_out_hi, alu_flags all 0.
  - Reset aborts any running op with no done pulse.
- Inputs are sampled only on the accepting edge (start=1, busy=0). Later input changes are ignored until done.
- start while busy=1: ignored, no queuing.
- FSM states:
  - IDLE:
    - start with a single-cycle op -> result written, done=1 next cycle, stay IDLE.
    - start with a multi-cycle op -> RUN, busy=1.
  - RUN:
    - Count register counts down. On the final iteration: write result, pulse done, go to IDLE; busy falls together with done.
- Single-cycle ops, latency 1 (single=0):
  - ADD, ADC: C = carry out.
  - SUB, SBC: C = borrow.
  - CMP: flags as SUB; bus_out keeps its previous value.
  - AND, OR, XOR, MOV: C unchanged, V=0.
- Single-cycle ops, latency 1 (single=1):
  - NEG, COM.
  - LSL, LSR, ROL, ROR, RLC, RRC by one bit: C = bit shifted out; ROL/ROR copy it to C.
- Multi-cycle ops (single=1, new codes):
  - LSLN, LSRN, ASRN, ROLN.
  - One bit per cycle; latency max(shamt,1) cycles.
  - shamt=0: result=value1, C unchanged, done after 1 cycle.
  - C = last bit shifted out; V=0.
- MUL (single=0, new code):
  - Unsigned shift-add, exactly WIDTH cycles of RUN, done pulses on the WIDTH-th cycle after accept.
  - {bus_out_hi, bus_out} = value1*value2.
  - C = (bus_out_hi != 0); V=0; Z,N from the full 2*WIDTH product.
- Overflow for ADD/ADC: operands share a sign and the result sign differs. For SUB/SBC/CMP: operand signs differ and the result sign differs from value1.
- Z = (result == 0); N = result MSB.
- Flags update only on the done cycle and hold otherwise.
- Undefined operator: bus_out=0, flags unchanged, done after 1 cycle.

Decomposition:
- cpu_data package holds all OP_* codes, including new OP_LSLN, OP_LSRN, OP_ASRN, OP_ROLN, OP_MUL, and flag bit-index constants FLAG_C/V/Z/N.
- One sub-module, alu_seq_comb: a purely combinational single-cycle datapath plus flag generation, parametrised by WIDTH.
- The top module keeps the FSM, counter, shift/multiply iteration registers and output registers.

Test Plan (WIDTH=8):
- ADD 0xFF+0x01, start at cycle 0 -> done at cycle 1, bus_out=0x00, flags C=1 V=0 Z=1 N=0.
- SUB 0x80-0x01 -> bus_out=0x7F, C=0 V=1 Z=0 N=0. CMP with the same operands -> same flags, bus_out unchanged at 0x7F.
- MUL 0xFF*0xFF -> done exactly 8 cycles after accept, busy high cycles 1..8, bus_out=0x01, bus_out_hi=0xFE, C=1. MUL 0x0F*0x11 -> 0xFF / 0x00, C=0.
- LSLN 0x81 with shamt=3 -> done after 3 cycles, 0x08, C=0. ASRN 0x80 with shamt=2 -> 0xE0, N=1. LSRN with shamt=0 -> value1 after 1 cycle, C unchanged.
- Start MUL, then reassert start with ADD at cycle 3 -> ADD ignored, MUL result unaffected, a single done pulse.
- Start MUL, then rst_n=0 at cycle 4 -> next edge: busy=0, done=0, all outputs 0, no done pulse. After release, ADD 0x02+0x03 -> 0x05.

Source files
------------

// File: rtl/cpu_data.sv
// Shared opcode, flag-index and FSM types for the sequential ALU.
// Imported by the datapath, the top and the bench.
package cpu_data;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;

  localparam logic [3:0] OP_NEG  = 4'h0;
  localparam logic [3:0] OP_COM  = 4'h1;
  localparam logic [3:0] OP_LSL  = 4'h2;
  localparam logic [3:0] OP_LSR  = 4'h3;
  localparam logic [3:0] OP_ROL  = 4'h4;
  localparam logic [3:0] OP_ROR  = 4'h5;
  localparam logic [3:0] OP_RLC  = 4'h6;
  localparam logic [3:0] OP_RRC  = 4'h7;
  localparam logic [3:0] OP_LSLN = 4'h8;
  localparam logic [3:0] OP_LSRN = 4'h9;
  localparam logic [3:0] OP_ASRN = 4'hA;
  localparam logic [3:0] OP_ROLN = 4'hB;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic [2:0] {
    M_LSL,
    M_LSR,
    M_ASR,
    M_ROL,
    M_MUL
  } mop_t;

  function automatic logic is_multi(
    input logic       single,
    input logic [3:0] op
  );
    if (single)
      return (op == OP_LSLN) || (op == OP_LSRN) ||
             (op == OP_ASRN) || (op == OP_ROLN);
    return op == OP_MUL;
  endfunction

  function automatic mop_t to_mop(
    input logic       single,
    input logic [3:0] op
  );
    mop_t m;
    m = M_MUL;
    if (single) begin
      case (op)
        OP_LSLN: m = M_LSL;
        OP_LSRN: m = M_LSR;
        OP_ASRN: m = M_ASR;
        default: m = M_ROL;
      endcase
    end
    return m;
  endfunction

  function automatic logic [3:0] pack_flags(
    input logic c,
    input logic v,
    input logic z,
    input logic n
  );
    logic [3:0] f;
    f = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath: arithmetic, logic and 1-bit shifts.
// Purely combinational; flags are raw, the top decides when to latch.
module alu_seq_comb
  import cpu_data::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             single,
  input  logic [3:0]       operator,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  input  logic             old_carry,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             wr_res,
  output logic             valid
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic [WIDTH:0] ngv;
  logic           cin;
  logic           bin;

  assign cin = !single && (operator == OP_ADC) && old_carry;
  assign bin = !single && (operator == OP_SBC) && old_carry;

  assign sum = {1'b0, value1} + {1'b0, value2}
             + {{WIDTH{1'b0}}, cin};
  assign dif = {1'b0, value1} - {1'b0, value2}
             - {{WIDTH{1'b0}}, bin};
  assign ngv = {(WIDTH+1){1'b0}} - {1'b0, value1};

  always_comb begin
    result   = '0;
    carry    = old_carry;
    overflow = 1'b0;
    wr_res   = 1'b1;
    valid    = 1'b1;
    if (!single) begin
      case (operator)
        OP_ADD, OP_ADC: begin
          result   = sum[M:0];
          carry    = sum[WIDTH];
          overflow = (value1[M] == value2[M]) &&
                     (sum[M] != value1[M]);
        end
        OP_SUB, OP_SBC, OP_CMP: begin
          result   = dif[M:0];
          carry    = dif[WIDTH];
          overflow = (value1[M] != value2[M]) &&
                     (dif[M] != value1[M]);
          wr_res   = (operator != OP_CMP);
        end
        OP_AND: result = value1 & value2;
        OP_OR:  result = value1 | value2;
        OP_XOR: result = value1 ^ value2;
        OP_MOV: result = value2;
        default: begin
          valid  = 1'b0;
          wr_res = 1'b0;
        end
      endcase
    end else begin
      case (operator)
        OP_NEG: begin
          result   = ngv[M:0];
          carry    = ngv[WIDTH];
          overflow = value1[M] && ngv[M];
        end
        OP_COM: result = ~value1;
        OP_LSL: begin
          result = {value1[M-1:0], 1'b0};
          carry  = value1[M];
        end
        OP_LSR: begin
          result = {1'b0, value1[M:1]};
          carry  = value1[0];
        end
        OP_ROL: begin
          result = {value1[M-1:0], value1[M]};
          carry  = value1[M];
        end
        OP_ROR: begin
          result = {value1[0], value1[M:1]};
          carry  = value1[0];
        end
        OP_RLC: begin
          result = {value1[M-1:0], old_carry};
          carry  = value1[M];
        end
        OP_RRC: begin
          result = {old_carry, value1[M:1]};
          carry  = value1[0];
        end
        default: begin
          valid  = 1'b0;
          wr_res = 1'b0;
        end
      endcase
    end
  end

  assign zero     = (result == '0);
  assign negative = result[M];

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: FSM, iteration registers, output latches.
// The first shift/multiply step happens on the accepting edge.
module alu_seq
  import cpu_data::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               single,
  input  logic [3:0]         operator,
  input  logic [WIDTH-1:0]   value1,
  input  logic [WIDTH-1:0]   value2,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               old_carry,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   bus_out,
  output logic [WIDTH-1:0]   bus_out_hi,
  output logic [3:0]         alu_flags
);

  localparam int CW = SHAMT_W + 1;
  localparam int M  = WIDTH - 1;

  state_t           state_q, state_d;
  mop_t             mop_q, mop_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [WIDTH-1:0] bhi_q, bhi_d;
  logic [3:0]       flg_q, flg_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] c_res;
  logic             c_c, c_v, c_z, c_n;
  logic             c_wr, c_ok;

  logic             accept, multi, step, fin, out_bit;
  mop_t             s_mop;
  logic [CW-1:0]    s_cnt;
  logic [WIDTH-1:0] s_a, s_lo, s_hi;
  logic [WIDTH-1:0] n_lo, n_hi;
  logic [WIDTH:0]   add_w;

  alu_seq_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .single   (single),
    .operator (operator),
    .value1   (value1),
    .value2   (value2),
    .old_carry(old_carry),
    .result   (c_res),
    .carry    (c_c),
    .overflow (c_v),
    .zero     (c_z),
    .negative (c_n),
    .wr_res   (c_wr),
    .valid    (c_ok)
  );

  always_comb begin
    accept  = start && !busy_q;
    multi   = is_multi(single, operator);
    state_d = state_q;
    mop_d   = mop_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    bus_d   = bus_q;
    bhi_d   = bhi_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    s_mop   = mop_q;
    s_cnt   = cnt_q;
    s_a     = a_q;
    s_lo    = lo_q;
    s_hi    = hi_q;
    step    = 1'b0;
    fin     = 1'b0;

    if (state_q == S_RUN) begin
      step = 1'b1;
    end else if (accept && multi) begin
      s_mop = to_mop(single, operator);
      s_a   = value1;
      s_hi  = '0;
      s_lo  = (s_mop == M_MUL) ? value2 : value1;
      s_cnt = (s_mop == M_MUL) ? CW'(WIDTH)
                               : CW'(shamt);
      if (s_cnt == '0) begin
        // zero-count shift passes value1 through
        done_d = 1'b1;
        bus_d  = value1;
        bhi_d  = '0;
        flg_d  = pack_flags(old_carry, 1'b0,
                            value1 == '0, value1[M]);
      end else begin
        step = 1'b1;
      end
    end else if (accept) begin
      done_d = 1'b1;
      bhi_d  = '0;
      if (!c_ok) begin
        bus_d = '0;
      end else begin
        if (c_wr)
          bus_d = c_res;
        flg_d = pack_flags(c_c, c_v, c_z, c_n);
      end
    end

    add_w   = {1'b0, s_hi}
            + (s_lo[0] ? {1'b0, s_a} : '0);
    n_lo    = s_lo;
    n_hi    = '0;
    out_bit = 1'b0;
    unique case (s_mop)
      M_LSL: begin
        n_lo    = {s_lo[M-1:0], 1'b0};
        out_bit = s_lo[M];
      end
      M_LSR: begin
        n_lo    = {1'b0, s_lo[M:1]};
        out_bit = s_lo[0];
      end
      M_ASR: begin
        n_lo    = {s_lo[M], s_lo[M:1]};
        out_bit = s_lo[0];
      end
      M_ROL: begin
        n_lo    = {s_lo[M-1:0], s_lo[M]};
        out_bit = s_lo[M];
      end
      default: begin
        n_hi = add_w[WIDTH:1];
        n_lo = {add_w[0], s_lo[M:1]};
      end
    endcase

    if (step) begin
      fin     = (s_cnt == CW'(1));
      mop_d   = s_mop;
      a_d     = s_a;
      lo_d    = n_lo;
      hi_d    = n_hi;
      cnt_d   = s_cnt - CW'(1);
      state_d = fin ? S_IDLE : S_RUN;
      if (fin) begin
        done_d = 1'b1;
        bus_d  = n_lo;
        if (s_mop == M_MUL) begin
          bhi_d = n_hi;
          flg_d = pack_flags(n_hi != '0, 1'b0,
                             {n_hi, n_lo} == '0, n_hi[M]);
        end else begin
          bhi_d = '0;
          flg_d = pack_flags(out_bit, 1'b0,
                             n_lo == '0, n_lo[M]);
        end
      end
    end

    // busy stays up through the done cycle of a multi-cycle op
    busy_d = (state_d == S_RUN) ||
             (fin && (state_q == S_RUN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mop_q   <= M_MUL;
      cnt_q   <= '0;
      a_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      bus_q   <= '0;
      bhi_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mop_q   <= mop_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      bus_q   <= bus_d;
      bhi_q   <= bhi_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bus_out    = bus_q;
  assign bus_out_hi = bhi_q;
  assign alu_flags  = flg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_alu_seq;
  import cpu_data::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       single;
  logic [3:0] operator;
  logic [7:0] value1, value2;
  logic [2:0] shamt;
  logic       old_carry;
  logic       busy, done;
  logic [7:0] bus_out, bus_out_hi;
  logic [3:0] alu_flags;

  int checks = 0;
  int errors = 0;
  bit [7:0] m_bus;
  bit [3:0] m_flg;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .single    (single),
    .operator  (operator),
    .value1    (value1),
    .value2    (value2),
    .shamt     (shamt),
    .old_carry (old_carry),
    .busy      (busy),
    .done      (done),
    .bus_out   (bus_out),
    .bus_out_hi(bus_out_hi),
    .alu_flags (alu_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       s;
    bit [3:0] op;
    bit [7:0] a;
    bit [7:0] b;
    bit [2:0] sh;
    bit       oc;
    bit [7:0] eb;
    bit [7:0] eh;
    bit [3:0] ef;
    int       el;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // flags {C,V,Z,N}; reference uses plain integer arithmetic
  task automatic model(input bit s, input bit [3:0] op,
                       input bit [7:0] a8, input bit [7:0] b8,
                       input bit [2:0] sh3, input bit oc,
                       output bit [7:0] eb, output bit [7:0] eh,
                       output bit [3:0] ef, output int el);
    int a, b, sa, sb, sh, r, sr, ci, p;
    bit c, v, wr, upd;
    a = a8; b = b8; sa = $signed(a8); sb = $signed(b8); sh = sh3;
    r = 0; sr = 0; ci = 0; p = 0;
    c = oc; v = 0; wr = 1; upd = 1; el = 1; eh = 0;
    if (!s) begin
      case (op)
        OP_ADD, OP_ADC: begin
          if (op == OP_ADC) ci = oc;
          r = a + b + ci; c = (r > 255);
          sr = sa + sb + ci; v = (sr > 127) || (sr < -128);
        end
        OP_SUB, OP_SBC, OP_CMP: begin
          if (op == OP_SBC) ci = oc;
          r = a - b - ci; c = (r < 0);
          sr = sa - sb - ci; v = (sr > 127) || (sr < -128);
          wr = (op != OP_CMP);
        end
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_XOR: r = a ^ b;
        OP_MOV: r = b;
        OP_MUL: begin
          p = a * b;
          el = 8;
          eb = 8'(p);
          eh = 8'(p / 256);
          ef = {eh != 0, 1'b0, p == 0, p[15]};
          return;
        end
        default: upd = 0;
      endcase
    end else begin
      case (op)
        OP_NEG: begin r = -a; c = (a != 0); v = (sa == -128); end
        OP_COM: r = 255 - a;
        OP_LSL: begin r = a * 2; c = a8[7]; end
        OP_LSR: begin r = a / 2; c = a8[0]; end
        OP_ROL: begin r = a * 2 + a / 128; c = a8[7]; end
        OP_ROR: begin r = a / 2 + (a % 2) * 128; c = a8[0]; end
        OP_RLC: begin r = a * 2 + int'(oc); c = a8[7]; end
        OP_RRC: begin r = a / 2 + int'(oc) * 128; c = a8[0]; end
        OP_LSLN, OP_LSRN, OP_ASRN, OP_ROLN: begin
          el = (sh > 1) ? sh : 1;
          if (op == OP_LSLN) r = a << sh;
          else if (op == OP_LSRN) r = a >> sh;
          else if (op == OP_ASRN) r = sa >>> sh;
          else r = (a << sh) | (a >> (8 - sh));
          if (sh != 0) begin
            if (op == OP_LSLN || op == OP_ROLN)
              c = ((a >> (8 - sh)) & 1) != 0;
            else
              c = ((a >> (sh - 1)) & 1) != 0;
          end
        end
        default: upd = 0;
      endcase
    end
    r = r & 255;
    eb = !upd ? 8'h00 : (wr ? 8'(r) : m_bus);
    ef = upd ? {c, v, r == 0, r[7]} : m_flg;
  endtask

  task automatic run(input string nm, input bit s, input bit [3:0] op,
                     input bit [7:0] a, input bit [7:0] b,
                     input bit [2:0] sh, input bit oc,
                     input bit [7:0] eb, input bit [7:0] eh,
                     input bit [3:0] ef, input int el);
    int lat;
    single = s; operator = op; value1 = a; value2 = b;
    shamt = sh; old_carry = oc; start = 1'b1;
    tick();
    start = 1'b0;
    single = 1'($urandom); operator = 4'($urandom);
    value1 = 8'($urandom); value2 = 8'($urandom);
    shamt = 3'($urandom); old_carry = 1'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, "_lat"}, lat, el);
    chk({nm, "_bus"}, bus_out, eb);
    chk({nm, "_hi"}, bus_out_hi, eh);
    chk({nm, "_flg"}, alu_flags, ef);
    m_bus = eb;
    m_flg = ef;
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int dn, done_at, busy_bad;
    bit [7:0] cap_b, cap_h;
    bit [3:0] cap_f;
    bit [7:0] eb, eh;
    bit [3:0] ef;
    int el;
    bit s;
    bit [3:0] op;
    bit [7:0] a, b;
    bit [2:0] sh;
    bit oc;

    tbl[0]  = '{0, OP_ADD,  8'hFF, 8'h01, 3'd0, 0, 8'h00, 8'h00, 4'b1010, 1};
    tbl[1]  = '{0, OP_SUB,  8'h80, 8'h01, 3'd0, 0, 8'h7F, 8'h00, 4'b0100, 1};
    tbl[2]  = '{0, OP_CMP,  8'h80, 8'h01, 3'd0, 0, 8'h7F, 8'h00, 4'b0100, 1};
    tbl[3]  = '{0, OP_MUL,  8'hFF, 8'hFF, 3'd0, 0, 8'h01, 8'hFE, 4'b1001, 8};
    tbl[4]  = '{0, OP_MUL,  8'h0F, 8'h11, 3'd0, 0, 8'hFF, 8'h00, 4'b0000, 8};
    tbl[5]  = '{1, OP_LSLN, 8'h81, 8'h00, 3'd3, 0, 8'h08, 8'h00, 4'b0000, 3};
    tbl[6]  = '{1, OP_ASRN, 8'h80, 8'h00, 3'd2, 0, 8'hE0, 8'h00, 4'b0001, 2};
    tbl[7]  = '{1, OP_LSRN, 8'h5A, 8'h00, 3'd0, 1, 8'h5A, 8'h00, 4'b1000, 1};
    tbl[8]  = '{0, 4'hF,    8'h12, 8'h34, 3'd0, 0, 8'h00, 8'h00, 4'b1000, 1};
    tbl[9]  = '{1, OP_LSRN, 8'h5A, 8'h00, 3'd0, 0, 8'h5A, 8'h00, 4'b0000, 1};
    tbl[10] = '{1, OP_ROLN, 8'h81, 8'h00, 3'd1, 0, 8'h03, 8'h00, 4'b1000, 1};
    tbl[11] = '{0, OP_ADC,  8'h7F, 8'h00, 3'd0, 1, 8'h80, 8'h00, 4'b0101, 1};
    tbl[12] = '{1, OP_RRC,  8'h01, 8'h00, 3'd0, 0, 8'h00, 8'h00, 4'b1010, 1};
    tbl[13] = '{1, OP_NEG,  8'h80, 8'h00, 3'd0, 0, 8'h80, 8'h00, 4'b1101, 1};

    rst_n = 1'b0; start = 1'b0; single = 1'b0; operator = OP_ADD;
    value1 = 8'h00; value2 = 8'h00; shamt = 3'd0; old_carry = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_hi", bus_out_hi, 0);
    chk("rst_flg", alu_flags, 0);
    rst_n = 1'b1;
    tick();
    m_bus = 0;
    m_flg = 0;

    for (int i = 0; i < 14; i++)
      run($sformatf("tbl%0d", i), tbl[i].s, tbl[i].op, tbl[i].a,
          tbl[i].b, tbl[i].sh, tbl[i].oc, tbl[i].eb, tbl[i].eh,
          tbl[i].ef, tbl[i].el);

    // MUL with a competing start while busy
    single = 1'b0; operator = OP_MUL; value1 = 8'hFF; value2 = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0; done_at = 0; busy_bad = 0;
    cap_b = 0; cap_h = 0; cap_f = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin
        start = 1'b1; single = 1'b0; operator = OP_ADD;
        value1 = 8'h02; value2 = 8'h03;
      end
      if (k == 8) start = 1'b0;
      if (busy !== (k <= 8)) busy_bad++;
      if (done) begin
        dn++; done_at = k;
        cap_b = bus_out; cap_h = bus_out_hi; cap_f = alu_flags;
      end
      tick();
    end
    chk("ign_pulses", dn, 1);
    chk("ign_done_at", done_at, 8);
    chk("ign_busy", busy_bad, 0);
    chk("ign_bus", cap_b, 8'h01);
    chk("ign_hi", cap_h, 8'hFE);
    chk("ign_flg", cap_f, 4'b1001);
    m_bus = 8'h01;
    m_flg = 4'b1001;

    // reset in the middle of a MUL
    single = 1'b0; operator = OP_MUL; value1 = 8'h37; value2 = 8'h5B;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bus", bus_out, 0);
    chk("abort_hi", bus_out_hi, 0);
    chk("abort_flg", alu_flags, 0);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) dn++;
      tick();
    end
    chk("abort_nodone", dn, 0);
    m_bus = 0;
    m_flg = 0;
    run("post_rst_add", 0, OP_ADD, 8'h02, 8'h03, 3'd0, 0,
        8'h05, 8'h00, 4'b0000, 1);

    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom);
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      sh = 3'($urandom);
      oc = 1'($urandom);
      model(s, op, a, b, sh, oc, eb, eh, ef, el);
      run($sformatf("rnd%0d_s%0d_op%0h", i, s, op),
          s, op, a, b, sh, oc, eb, eh, ef, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
